// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, line levels and baud helper (PARITY state only with UART_TX_PARITY_EN).
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b1;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP  = 3'd4
  } tx_state_t;
  function automatic int baud_ticks(input int clk_speed, input int baud_rate);
    return clk_speed / baud_rate;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: per-bit cycle counter with sync clear/enable and a last-cycle strobe.
module uart_baud_tick #(
  parameter int BAUD_TICK = 16,
  parameter int WIDTH = $clog2(BAUD_TICK)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_last_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  assign tick_last_o = cnt_q == WIDTH'(BAUD_TICK - 1);
  always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tick_last_o ? '0 : cnt_q + WIDTH'(1);
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 serial transmitter with valid/ready byte intake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmit
  import uart_pkg::*;
#(
  parameter int CLK_SPEED = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       finished_send
);
  localparam int BAUD_TICK = baud_ticks(CLK_SPEED, BAUD_RATE);
  localparam int BAUD_TICK_WIDTH = $clog2(BAUD_TICK);
  tx_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic tx_q, tx_d;
  logic tick_last;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  uart_baud_tick #(.BAUD_TICK(BAUD_TICK), .WIDTH(BAUD_TICK_WIDTH)) u_tick (
    .clk(clock),
    .rst(reset),
    .clr_i(ready),
    .en_i(busy),
    .tick_last_o(tick_last)
  );
  assign ready = state_q == IDLE;
  assign busy = ~ready;
  assign tx = tx_q;
  assign finished_send = state_q == STOP && tick_last;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: if (send) begin
        state_d = START;
        shift_d = data_in;
        bit_d = '0;
`ifdef UART_TX_PARITY_EN
        par_d = ^data_in;
`endif
      end
      START: if (tick_last) state_d = DATA;
      DATA: if (tick_last) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick_last) state_d = STOP;
`endif
      STOP: if (tick_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // tx is driven from the next state so the line changes on the same edge as the FSM
    tx_d = state_d == START ? START_LEVEL : state_d == DATA ? shift_d[0] : state_d == STOP ? STOP_LEVEL : IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
    if (state_d == PARITY) tx_d = par_q;
`endif
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q <= '0;
      tx_q <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
    end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock)
    if (reset) par_q <= 1'b0;
    else par_q <= par_d;
`endif
endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: scoreboard bench; a line monitor decodes frames from tx and tasks compare them to queued bytes.
module tb_uart_transmit;
  localparam int BT = 16;
`ifdef UART_TX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int FL = BITS * BT;
  typedef struct {
    logic [BITS-1:0] bits;
    int start;
  } rx_t;
  logic clock = 1'b0, reset = 1'b1, send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic ready, tx, busy, finished_send;
  int cyc = 0, fin_cnt = 0, n_checks = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  rx_t rx_q[$];

  uart_transmit #(.CLK_SPEED(16), .BAUD_RATE(1)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .send(send),
    .ready(ready), .tx(tx), .busy(busy), .finished_send(finished_send)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (finished_send === 1'b1) fin_cnt++;

  initial forever begin
    @(negedge clock);
    if (tx === 1'b0 && reset === 1'b0) begin
      rx_t r;
      bit ab;
      r.start = cyc;
      r.bits = '0;
      ab = 1'b0;
      for (int k = 0; k < FL; k++) begin
        if (reset === 1'b1) begin ab = 1'b1; break; end
        if (k % BT == BT / 2) r.bits[k / BT] = tx;
        if (k < FL - 1) @(negedge clock);
      end
      if (!ab) rx_q.push_back(r);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [BITS-1:0] frame_of(input logic [7:0] b);
    logic [BITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    data_in = b;
    send = 1'b1;
    exp_q.push_back(b);
    step();
    send = 1'b0;
    acc = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    send = 1'b0;
    repeat (3) begin
      step();
      n_checks++;
      if ({tx, ready, busy, finished_send} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_state: tx/ready/busy/fin=%b want 1100", {tx, ready, busy, finished_send});
      end
    end
    reset = 1'b0;
    repeat (5) step();
    n_checks++;
    if ({tx, ready, busy, finished_send} !== 4'b1100 || rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: tx/ready/busy/fin=%b frames=%0d want 1100 and 0", {tx, ready, busy, finished_send}, rx_q.size());
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    int a;
    logic [BITS-1:0] f;
    rx_t r;
    logic [7:0] e;
    f = frame_of(b);
    send_byte(b, a);
    for (int k = 0; k < FL; k++) begin
      n_checks++;
      if ({tx, finished_send, ready} !== {f[k / BT], k == FL - 1, 1'b0}) begin
        n_fail++;
        $display("FAIL single_wave cycle %0d: tx/fin/ready=%b want %b", k, {tx, finished_send, ready}, {f[k / BT], k == FL - 1, 1'b0});
      end
      step();
    end
    n_checks++;
    if ({tx, ready, busy, finished_send} !== 4'b1100) begin
      n_fail++;
      $display("FAIL single_end: tx/ready/busy/fin=%b want 1100", {tx, ready, busy, finished_send});
    end
    n_checks++;
    if (rx_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL single_sb: frames=%0d expected=%0d want both nonzero", rx_q.size(), exp_q.size());
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      if (r.bits !== frame_of(e) || r.start !== a) begin
        n_fail++;
        $display("FAIL single_sb: frame=%b start=%0d want %b start=%0d", r.bits, r.start, frame_of(e), a);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int a;
    rx_t r;
    logic [7:0] e;
    send_byte(8'h0F, a);
    repeat (49) step();
    data_in = 8'hFF;
    send = 1'b1;
    repeat (5) step();
    send = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready: ready=%b want 0", ready);
    end
    for (int i = 0; i < 2 * FL && ready !== 1'b1; i++) step();
    n_checks++;
    if (ready !== 1'b1 || cyc !== a + FL) begin
      n_fail++;
      $display("FAIL busy_done: ready=%b at cycle %0d want 1 at %0d", ready, cyc, a + FL);
    end
    repeat (3 * BT) begin
      step();
      n_checks++;
      if ({tx, ready} !== 2'b11) begin
        n_fail++;
        $display("FAIL busy_no_requeue: tx/ready=%b want 11", {tx, ready});
      end
    end
    n_checks++;
    if (rx_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL busy_sb: frames=%0d expected=%0d want 1 and 1", rx_q.size(), exp_q.size());
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      if (r.bits !== frame_of(e)) begin
        n_fail++;
        $display("FAIL busy_sb: frame=%b want %b", r.bits, frame_of(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2;
    rx_t r1, r2;
    logic [7:0] e1, e2;
    data_in = 8'h00;
    send = 1'b1;
    exp_q.push_back(8'h00);
    step();
    a1 = cyc;
    data_in = 8'hFF;
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 2 * FL && ready !== 1'b1; i++) step();
    n_checks++;
    if ({ready, tx} !== 2'b11 || cyc !== a1 + FL) begin
      n_fail++;
      $display("FAIL b2b_gap: ready/tx=%b at cycle %0d want 11 at %0d", {ready, tx}, cyc, a1 + FL);
    end
    step();
    a2 = cyc;
    send = 1'b0;
    n_checks++;
    if (tx !== 1'b0 || a2 - a1 !== FL + 1) begin
      n_fail++;
      $display("FAIL b2b_restart: tx=%b spacing=%0d want 0 and %0d", tx, a2 - a1, FL + 1);
    end
    for (int i = 0; i < 2 * FL && rx_q.size() < 2; i++) step();
    n_checks++;
    if (rx_q.size() != 2 || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_sb: frames=%0d expected=%0d want 2 and 2", rx_q.size(), exp_q.size());
    end else begin
      r1 = rx_q.pop_front();
      r2 = rx_q.pop_front();
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      if (r1.bits !== frame_of(e1) || r2.bits !== frame_of(e2) || r2.start - r1.start !== FL + 1) begin
        n_fail++;
        $display("FAIL b2b_sb: frames=%b,%b gap=%0d want %b,%b gap=%0d", r1.bits, r2.bits, r2.start - r1.start, frame_of(e1), frame_of(e2), FL + 1);
      end
    end
    for (int i = 0; i < 2 * FL && ready !== 1'b1; i++) step();
  endtask

  task automatic test_reset_mid();
    int a, fc;
    send_byte(8'h00, a);
    void'(exp_q.pop_back());
    repeat (70) step();
    fc = fin_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({tx, ready, busy, finished_send} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_mid_state: tx/ready/busy/fin=%b want 1100", {tx, ready, busy, finished_send});
    end
    repeat (FL) step();
    n_checks++;
    if (fin_cnt !== fc || rx_q.size() != 0 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_abort: fin_pulses=%0d frames=%0d tx=%b want 0, 0, 1", fin_cnt - fc, rx_q.size(), tx);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] b, input logic want);
    int a;
    rx_t r;
    logic [7:0] e;
    send_byte(b, a);
    for (int i = 0; i < 2 * FL && ready !== 1'b1; i++) step();
    n_checks++;
    if (cyc !== a + 176) begin
      n_fail++;
      $display("FAIL parity_len: frame took %0d cycles want 176", cyc - a);
    end
    n_checks++;
    if (rx_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL parity_sb: frames=%0d expected=%0d want both nonzero", rx_q.size(), exp_q.size());
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      if (r.bits[9] !== want || r.bits !== frame_of(e)) begin
        n_fail++;
        $display("FAIL parity_sb: parity=%b frame=%b want %b and %b", r.bits[9], r.bits, want, frame_of(e));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single(8'hA5);
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_single(8'h3C);
`ifdef UART_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
